// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in, parallel-out receiver: state encoding,
// default word width and the bit-counter width helper.
package sipo_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } sipo_state_t;

    localparam int DEF_WIDTH = 7;

    // Enough bits to index positions 0..width-1, never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/sipo7_rx_if.sv
// Serial link plus parallel word output of the receiver; master drives the
// serial side, slave is the receiver.
interface sipo7_rx_if import sipo_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             din;
    logic             bit_en;
    logic             start;
    logic [WIDTH-1:0] dataout;
    logic             data_valid;
    logic             busy;
    logic             abort;

    modport master (
        output din,
        output bit_en,
        output start,
        input  dataout,
        input  data_valid,
        input  busy,
        input  abort
    );

    modport slave (
        input  din,
        input  bit_en,
        input  start,
        output dataout,
        output data_valid,
        output busy,
        output abort
    );

endinterface

// File: rtl/sipo_bitcnt.sv
// Bit-position counter for the receiver: clear, load-to-1 and increment,
// with a terminal-count flag when sitting on the last bit position.
module sipo_bitcnt import sipo_pkg::*; #(
    parameter  int WIDTH = DEF_WIDTH,
    localparam int CW    = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load1,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    // Clear beats load beats increment.
    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (load1) begin
            cnt_next = CW'(1);
        end else if (en) begin
            cnt_next = cnt_reg + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt = cnt_reg;
    assign tc  = (cnt_reg == LAST);

endmodule

// File: rtl/sipo7_rx.sv
// Serial-in, parallel-out receiver: frames words with a start marker, assembles
// WIDTH bits and presents the word with a one-cycle valid strobe.
module sipo7_rx import sipo_pkg::*; #(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    sipo7_rx_if.slave  bus
);

    localparam int CW = cnt_width(WIDTH);

    sipo_state_t      state_reg;
    sipo_state_t      state_next;
    logic [CW-1:0]    cnt;
    logic             tc;
    logic             cnt_clr;
    logic             cnt_load;
    logic             cnt_en;
    logic             ctl_first;
    logic             ctl_store;
    logic             ctl_done;
    logic             ctl_abort;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] dataout_reg;
    logic             valid_reg;
    logic             abort_reg;
    logic [WIDTH-1:0] first_mask;
    logic [WIDTH-1:0] wr_mask;
    logic [WIDTH-1:0] first_word;
    logic [WIDTH-1:0] merged_word;

    sipo_bitcnt #(
        .WIDTH (WIDTH)
    ) u_bitcnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .load1 (cnt_load),
        .en    (cnt_en),
        .cnt   (cnt),
        .tc    (tc)
    );

    // Bit 0 of a frame lands at the low end, or the high end when mirrored;
    // later bits land at position cnt, mirrored the same way.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_mask
            assign first_mask[gi] = (LSB_FIRST != 1'b0) ? (gi == 0) : (gi == WIDTH - 1);
            assign wr_mask[gi]    = (cnt == CW'((LSB_FIRST != 1'b0) ? gi : (WIDTH - 1 - gi)));
        end
    endgenerate

    // A new frame starts from an all-zero word so stale bits never leak.
    assign first_word  = first_mask & {WIDTH{bus.din}};
    assign merged_word = shift_reg | (wr_mask & {WIDTH{bus.din}});

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.bit_en && bus.start) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.bit_en && !bus.start && tc) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A start inside a frame wins over everything, including the last bit.
    always_comb begin
        ctl_first = 1'b0;
        ctl_store = 1'b0;
        ctl_done  = 1'b0;
        ctl_abort = 1'b0;
        cnt_clr   = 1'b0;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.bit_en && bus.start) begin
                    ctl_first = 1'b1;
                    cnt_load  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (bus.bit_en) begin
                    if (bus.start) begin
                        ctl_first = 1'b1;
                        ctl_abort = 1'b1;
                        cnt_load  = 1'b1;
                    end else if (tc) begin
                        ctl_done = 1'b1;
                        cnt_clr  = 1'b1;
                    end else begin
                        ctl_store = 1'b1;
                        cnt_en    = 1'b1;
                    end
                end
            end
            default: cnt_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_reg   <= '0;
            dataout_reg <= '0;
            valid_reg   <= 1'b0;
            abort_reg   <= 1'b0;
        end else begin
            valid_reg <= ctl_done;
            abort_reg <= ctl_abort;
            if (ctl_first) begin
                shift_reg <= first_word;
            end else if (ctl_store) begin
                shift_reg <= merged_word;
            end else if (ctl_done) begin
                shift_reg   <= '0;
                dataout_reg <= merged_word;
            end
        end
    end

    assign bus.dataout    = dataout_reg;
    assign bus.data_valid = valid_reg;
    assign bus.abort      = abort_reg;
    assign bus.busy       = (state_reg == ST_SHIFT);

endmodule

// File: doc/sipo7_rx.md
Name: sipo7_rx

Overview:
Serial-in, parallel-out receiver that reassembles words from the 7-bit serial shift stream used by the team's parallel-in, serial-out shifter (LSB first, one bit per qualified clock). A start marker frames each word, and a bit counter tracks position within it. The completed word is presented on a parallel bus with a one-cycle valid strobe. The block sits at the receiving end of that link: in digital-fundamentals demos and in loopback benches against the shifter.

Parameters:
WIDTH, 7, bits per word (legal range 2..32)
LSB_FIRST, 1, 1 = first received bit lands in dataout[0]; 0 = first bit lands in dataout[WIDTH-1]

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  reset, synchronous, active-low
din  in  1  serial data bit
bit_en  in  1  qualifies din this cycle; a bit is consumed only when bit_en=1
start  in  1  frame marker; meaningful only with bit_en=1, marks din as bit 0 of a new word
dataout  out  WIDTH  last completed word, held until the next completion
data_valid  out  1  one-cycle pulse: dataout updated this cycle
busy  out  1  1 while a frame is partially received
abort  out  1  one-cycle pulse: partial frame discarded by a restart

Behaviour:
- Reset: rst sampled low at a clk edge -> state IDLE, bit counter 0, shift register 0, dataout 0, data_valid 0, busy 0, abort 0. Reset mid-frame discards the partial word silently; no abort pulse.
- Two states: IDLE and SHIFT. Counter width is clog2(WIDTH).
- IDLE: bit_en=1 & start=1 -> capture din as bit 0, cnt<=1, go to SHIFT, busy<=1. bit_en=1 & start=0 -> bit ignored. start=1 with bit_en=0 -> ignored.
- SHIFT, bit_en=0 -> hold all state (gaps of any length allowed).
- SHIFT, bit_en=1 & start=0 -> store din at position cnt (mirrored when LSB_FIRST=0), cnt<=cnt+1.
- Last bit (cnt==WIDTH-1, bit_en=1, start=0):
  - At that edge, dataout<=assembled word including this bit, data_valid<=1 for exactly one cycle, state<=IDLE, busy<=0, cnt<=0.
  - Latency: the word is visible on the cycle after its last bit's edge.
- SHIFT, bit_en=1 & start=1 (any cnt, including the last bit):
  - The restart wins: the partial word is discarded and abort pulses for one cycle.
  - din becomes bit 0 of the new frame, cnt<=1, state stays SHIFT.
  - dataout is unchanged and data_valid stays 0.
- Back-to-back frames: a start on the cycle immediately after completion is accepted (IDLE accepts it), so no dead cycle is required.
- Unused shift-register bits never leak: each new frame starts with the register cleared before bit 0 is written.
- dataout changes only on completion or reset.
- data_valid and abort are never asserted in the same cycle.

Decomposition:
- Shared package sipo_pkg holds the state encoding (ST_IDLE, ST_SHIFT), the default WIDTH constant 7, and a function computing counter width from WIDTH.
- One natural sub-module: sipo_bitcnt, a loadable counter with a terminal-count flag at WIDTH-1, clear, load-to-1 and enable.
- The shift/assemble path and the FSM stay in the top module.

Test Plan:
- Word 7'h59, LSB first: send bits 1,0,0,1,1,0,1 on 7 consecutive cycles, start on the first -> one cycle later dataout=7'h59, data_valid=1 for one cycle, busy 1->0.
- Same word with bit_en gaps: 3 idle cycles after bit 2, 5 after bit 5 -> dataout=7'h59, exactly one data_valid, busy stays high through the gaps.
- Restart: send 4 bits of 7'h7F, then start with bits of 7'h12 -> abort pulses once on the restart cycle; dataout=7'h12 at the end; no data_valid for 7'h7F.
- Back-to-back: 7'h2A immediately followed by 7'h55 (start on the cycle after the last bit) -> two data_valid pulses 7 cycles apart, values 7'h2A then 7'h55.
- Reset mid-frame: rst low after 3 bits -> next edge gives all outputs 0. Then receive 7'h01 -> dataout=7'h01, no stale bits, no abort.
- LSB_FIRST=0, WIDTH=8: send bits 1,0,1,1,0,0,0,1 -> dataout=8'hB1. Bits sent with start=0 while IDLE produce no output.
